// File: rtl/window_pointer_unit.sv
// SPARC register-window pointer (CWP/WIM, SAVE/RESTORE traps) and logical-to-physical
// register address mapper. Define WIN_DEPTH_EN to add the saturating call-depth output Depth.
module window_pointer_unit #(
   parameter int NWINDOWS = 4,
   parameter int CWP_W    = 4
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic                Save,
   input  logic                Restore,
   input  logic                CwpLd,
   input  logic [CWP_W-1:0]    CwpIn,
   input  logic                WimLd,
   input  logic [NWINDOWS-1:0] WimIn,
   input  logic                AddrValid,
   input  logic [4:0]          LogAddr,
   output logic [CWP_W-1:0]    Cwp,
   output logic [NWINDOWS-1:0] Wim,
   output logic [7:0]          PhysAddr,
   output logic                PhysLd,
   output logic                WinOverflow,
   output logic                WinUnderflow,
   output logic                BadOp
`ifdef WIN_DEPTH_EN
   ,
   output logic [3:0]          Depth
`endif
);

   localparam int               RING     = 16 * NWINDOWS;
   localparam logic [CWP_W-1:0] LAST_WIN = CWP_W'(NWINDOWS - 1);

   logic [CWP_W-1:0]    cwp_q, cwp_d;
   logic [NWINDOWS-1:0] wim_q, wim_d;
   logic [7:0]          phys_addr_q, phys_addr_d;
   logic                phys_ld_q, phys_ld_d;
   logic                overflow_q, overflow_d;
   logic                underflow_q, underflow_d;
   logic                bad_op_q, bad_op_d;
`ifdef WIN_DEPTH_EN
   logic [3:0]          depth_q, depth_d;
`endif

   logic [CWP_W-1:0]    save_tgt, restore_tgt, cwp_ld_val;
   logic                save_blocked, restore_blocked;
   logic [8:0]          win_offset, ring_offset;

   // Neighbouring windows and the trap lookup against the pre-edge WIM.
   always_comb begin
      save_tgt        = (cwp_q == '0) ? LAST_WIN : cwp_q - CWP_W'(1);
      restore_tgt     = (cwp_q == LAST_WIN) ? '0 : cwp_q + CWP_W'(1);
      cwp_ld_val      = CWP_W'(int'(CwpIn) % NWINDOWS);
      save_blocked    = 1'b0;
      restore_blocked = 1'b0;
      for (int i = 0; i < NWINDOWS; i++) begin
         if (save_tgt == CWP_W'(i))    save_blocked    = wim_q[i];
         if (restore_tgt == CWP_W'(i)) restore_blocked = wim_q[i];
      end
   end

   // Windowed registers live in a ring of 16*NWINDOWS entries above the 8 globals; the
   // offset never reaches twice the ring size, so one conditional subtract wraps it.
   always_comb begin
      win_offset  = 9'({cwp_q, 4'b0000}) + 9'(LogAddr) - 9'd8;
      ring_offset = (win_offset >= 9'(RING)) ? win_offset - 9'(RING) : win_offset;
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path through this block infers a latch.
      cwp_d       = cwp_q;
      wim_d       = WimLd ? WimIn : wim_q;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      bad_op_d    = 1'b0;
      phys_ld_d   = AddrValid;
      phys_addr_d = phys_addr_q;
`ifdef WIN_DEPTH_EN
      depth_d     = depth_q;
`endif

      if (AddrValid) begin
         phys_addr_d = (LogAddr < 5'd8) ? {3'b000, LogAddr} : 8'(ring_offset + 9'd8);
      end

      if (CwpLd) begin
         cwp_d = cwp_ld_val;
`ifdef WIN_DEPTH_EN
         depth_d = '0;
`endif
      end else if (Save && Restore) begin
         bad_op_d = 1'b1;
      end else if (Save) begin
         if (save_blocked) begin
            overflow_d = 1'b1;
         end else begin
            cwp_d = save_tgt;
`ifdef WIN_DEPTH_EN
            if (depth_q != 4'd15) depth_d = depth_q + 4'd1;
`endif
         end
      end else if (Restore) begin
         if (restore_blocked) begin
            underflow_d = 1'b1;
         end else begin
            cwp_d = restore_tgt;
`ifdef WIN_DEPTH_EN
            if (depth_q != 4'd0) depth_d = depth_q - 4'd1;
`endif
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cwp_q       <= '0;
         wim_q       <= '0;
         phys_addr_q <= '0;
         phys_ld_q   <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         bad_op_q    <= 1'b0;
`ifdef WIN_DEPTH_EN
         depth_q     <= '0;
`endif
      end else begin
         cwp_q       <= cwp_d;
         wim_q       <= wim_d;
         phys_addr_q <= phys_addr_d;
         phys_ld_q   <= phys_ld_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         bad_op_q    <= bad_op_d;
`ifdef WIN_DEPTH_EN
         depth_q     <= depth_d;
`endif
      end
   end

   assign Cwp          = cwp_q;
   assign Wim          = wim_q;
   assign PhysAddr     = phys_addr_q;
   assign PhysLd       = phys_ld_q;
   assign WinOverflow  = overflow_q;
   assign WinUnderflow = underflow_q;
   assign BadOp        = bad_op_q;
`ifdef WIN_DEPTH_EN
   assign Depth        = depth_q;
`endif

endmodule

// File: tb/tb_window_pointer_unit.sv
// Scoreboard bench for window_pointer_unit: the driver pushes expected responses from a
// window-arithmetic reference model, and a monitor compares them one cycle later.
module tb_window_pointer_unit;

   localparam int NW = 4;
   localparam int CW = 4;

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b1;
   logic          Save = 1'b0, Restore = 1'b0, CwpLd = 1'b0, WimLd = 1'b0, AddrValid = 1'b0;
   logic [CW-1:0] CwpIn = '0;
   logic [NW-1:0] WimIn = '0;
   logic [4:0]    LogAddr = '0;
   logic [CW-1:0] Cwp;
   logic [NW-1:0] Wim;
   logic [7:0]    PhysAddr;
   logic          PhysLd, WinOverflow, WinUnderflow, BadOp;
`ifdef WIN_DEPTH_EN
   logic [3:0]    Depth;
`endif

   window_pointer_unit #(.NWINDOWS(NW), .CWP_W(CW)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Save(Save), .Restore(Restore),
      .CwpLd(CwpLd), .CwpIn(CwpIn), .WimLd(WimLd), .WimIn(WimIn),
      .AddrValid(AddrValid), .LogAddr(LogAddr), .Cwp(Cwp), .Wim(Wim),
      .PhysAddr(PhysAddr), .PhysLd(PhysLd), .WinOverflow(WinOverflow),
      .WinUnderflow(WinUnderflow), .BadOp(BadOp)
`ifdef WIN_DEPTH_EN
      , .Depth(Depth)
`endif
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int cwp;
      int wim;
      int phys_ld;
      int ovf;
      int unf;
      int bad;
      int depth;
   } exp_t;

   exp_t exp_q[$];
   int   addr_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   // Reference model state: window number, invalid mask and call depth as plain integers.
   int   m_cwp = 0, m_wim = 0, m_depth = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int map_addr(input int cwp, input int la);
      if (la < 8) return la;
      return 8 + ((16 * cwp + la - 8) % (16 * NW));
   endfunction

   task automatic cycle(input bit s, input bit r, input bit cl, input int ci,
                        input bit wl, input int wi, input bit av, input int la);
      exp_t e;
      int   tgt;
      @(negedge Clk);
      Save = s; Restore = r; CwpLd = cl; CwpIn = CW'(ci);
      WimLd = wl; WimIn = NW'(wi); AddrValid = av; LogAddr = 5'(la);

      e = '{default: 0};
      e.phys_ld = int'(av);
      if (av) addr_q.push_back(map_addr(m_cwp, la));
      if (cl) begin
         m_cwp   = ci % NW;
         m_depth = 0;
      end else if (s && r) begin
         e.bad = 1;
      end else if (s) begin
         tgt = (m_cwp + NW - 1) % NW;
         if ((m_wim >> tgt) & 1) e.ovf = 1;
         else begin
            m_cwp   = tgt;
            m_depth = (m_depth < 15) ? m_depth + 1 : 15;
         end
      end else if (r) begin
         tgt = (m_cwp + 1) % NW;
         if ((m_wim >> tgt) & 1) e.unf = 1;
         else begin
            m_cwp   = tgt;
            m_depth = (m_depth > 0) ? m_depth - 1 : 0;
         end
      end
      if (wl) m_wim = wi;
      e.cwp   = m_cwp;
      e.wim   = m_wim;
      e.depth = m_depth;
      exp_q.push_back(e);
      mon_en = 1'b1;
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Async reset asserted mid-cycle with a BadOp pending on the inputs; it must be dropped.
   task automatic do_reset();
      @(negedge Clk);
      mon_en = 1'b0;
      Save = 1'b1; Restore = 1'b1; AddrValid = 1'b1; LogAddr = 5'd20;
      #2 Reset_n = 1'b0;
      #1;
      check("rst_cwp", int'(Cwp), 0);
      check("rst_wim", int'(Wim), 0);
      check("rst_phys_addr", int'(PhysAddr), 0);
      check("rst_phys_ld", int'(PhysLd), 0);
      check("rst_ovf", int'(WinOverflow), 0);
      check("rst_unf", int'(WinUnderflow), 0);
      @(posedge Clk);
      #1;
      check("rst_bad_dropped", int'(BadOp), 0);
      check("rst_ld_held", int'(PhysLd), 0);
`ifdef WIN_DEPTH_EN
      check("rst_depth", int'(Depth), 0);
`endif
      @(negedge Clk);
      Save = 1'b0; Restore = 1'b0; CwpLd = 1'b0; WimLd = 1'b0; AddrValid = 1'b0;
      Reset_n = 1'b1;
      m_cwp = 0; m_wim = 0; m_depth = 0;
   endtask

   // Monitor: pops one expected record per cycle, and one expected address per PhysLd.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (mon_en) begin
            check("exp_queue_nonempty", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("cwp", int'(Cwp), e.cwp);
               check("wim", int'(Wim), e.wim);
               check("phys_ld", int'(PhysLd), e.phys_ld);
               check("win_overflow", int'(WinOverflow), e.ovf);
               check("win_underflow", int'(WinUnderflow), e.unf);
               check("bad_op", int'(BadOp), e.bad);
`ifdef WIN_DEPTH_EN
               check("depth", int'(Depth), e.depth);
`endif
            end
            if (PhysLd) begin
               check("addr_queue_nonempty", int'(addr_q.size() > 0), 1);
               if (addr_q.size() > 0) check("phys_addr", int'(PhysAddr), addr_q.pop_front());
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      int r, wi;
      #12;
      do_reset();

      // Mapping at window 0, back-to-back and then one idle cycle.
      cycle(0, 0, 0, 0, 0, 0, 1, 5);
      cycle(0, 0, 0, 0, 0, 0, 1, 8);
      cycle(0, 0, 0, 0, 0, 0, 1, 16);
      cycle(0, 0, 0, 0, 0, 0, 1, 24);
      cycle(0, 0, 0, 0, 0, 0, 1, 31);
      idle();

      // SAVE wraps 0 -> 3; r24 there aliases r8 of window 0; RESTORE wraps back.
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 1, 24);
      cycle(0, 1, 0, 0, 0, 0, 1, 24);
      cycle(1, 0, 0, 0, 0, 0, 1, 9);
      cycle(0, 0, 0, 0, 0, 0, 1, 9);

      // Overflow and underflow traps at window 3.
      cycle(0, 0, 0, 0, 1, 4'b0100, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 4'b0001, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 0, 0);
      idle();
      cycle(0, 0, 0, 0, 1, 0, 0, 0);

      // BadOp, then CwpLd priority and out-of-range CwpIn.
      cycle(0, 0, 1, 1, 0, 0, 0, 0);
      cycle(1, 1, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 1, 2, 0, 0, 0, 0);
      cycle(1, 1, 1, 13, 0, 0, 1, 30);
      cycle(0, 0, 1, 0, 0, 0, 0, 0);

      // Depth: 3 SAVEs, 1 RESTORE, masked SAVE, then saturation both ways.
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 1, 4'b0010, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 17; i++) cycle(1, 0, 0, 0, 0, 0, 1, 8 + i);
      for (int i = 0; i < 17; i++) cycle(0, 1, 0, 0, 0, 0, 1, 31 - i);
      idle();

      // Randomized traffic, a mid-run reset, and more traffic afterwards.
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 99);
            wi = $urandom_range(0, 15) & $urandom_range(0, 15);
            cycle(r < 35, r >= 30 && r < 65, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 15), $urandom_range(0, 9) == 0, wi,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 31));
         end
         idle();
         do_reset();
      end

      check("exp_queue_drained", exp_q.size(), 0);
      check("addr_queue_drained", addr_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/window_pointer_unit.md
Name: window_pointer_unit

Overview:
- SPARC register-window pointer and logical-to-physical register address mapper, directly upstream of the register-file write-enable decoders.
- Holds CWP and WIM and executes SAVE/RESTORE with overflow/underflow detection.
- Translates a 5-bit logical register number (r0-r31) into a registered physical register address, plus a load strobe that drives the decoder Ld input.

Parameters:
- NWINDOWS, 4, number of register windows; legal range 2..15.
- CWP_W, 4, CWP width in bits; must satisfy 2^CWP_W >= NWINDOWS.

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset_n  input  1  asynchronous active-low reset.
- Save  input  1  execute SAVE this cycle.
- Restore  input  1  execute RESTORE this cycle.
- CwpLd  input  1  load CWP from CwpIn (WRPSR path).
- CwpIn  input  CWP_W  new CWP value.
- WimLd  input  1  load WIM from WimIn.
- WimIn  input  NWINDOWS  new window invalid mask.
- AddrValid  input  1  LogAddr is valid this cycle.
- LogAddr  input  5  logical register number.
- Cwp  output  CWP_W  current window pointer.
- Wim  output  NWINDOWS  current window invalid mask.
- PhysAddr  output  8  registered physical register address.
- PhysLd  output  1  registered AddrValid; drives the decoder Ld.
- WinOverflow  output  1  one-cycle pulse: SAVE hit an invalid window.
- WinUnderflow  output  1  one-cycle pulse: RESTORE hit an invalid window.
- BadOp  output  1  one-cycle pulse: Save and Restore asserted together.

Behaviour:
- Reset (async, Reset_n=0): Cwp=0, Wim=0, PhysAddr=0, PhysLd=0, all pulse outputs 0. Release is synchronous to the next Clk edge.
- All state and outputs update on the rising Clk edge. Pulse outputs are high for exactly one cycle.
- SAVE: target = (Cwp-1) mod NWINDOWS.
  - Wim[target]=1: Cwp unchanged, WinOverflow=1 next cycle.
  - Otherwise: Cwp <= target.
  - Wrap: Cwp=0 goes to NWINDOWS-1.
- RESTORE: target = (Cwp+1) mod NWINDOWS.
  - Wim[target]=1: Cwp unchanged, WinUnderflow=1 next cycle.
  - Otherwise: Cwp <= target.
  - Wrap: Cwp=NWINDOWS-1 goes to 0.
- Save and Restore in the same cycle: neither executes, BadOp=1 next cycle, Cwp unchanged.
- CwpLd has priority over Save/Restore/BadOp.
  - Cwp <= CwpIn if CwpIn < NWINDOWS; otherwise Cwp <= CwpIn mod NWINDOWS.
  - No trap pulses are generated in a CwpLd cycle.
- WimLd is independent and may coincide with Save/Restore. The trap check uses the pre-edge Wim.
- Address map, computed from the pre-edge Cwp (a same-cycle SAVE affects only the next access):
  - r0-r7: PhysAddr = LogAddr (globals 0-7).
  - r8-r31: PhysAddr = 8 + ((16*Cwp + (LogAddr-8)) mod (16*NWINDOWS)).
  - Window w occupies outs at 16w+8..16w+15, locals at 16w+16..16w+23, ins at 16w+24..16w+31 (wrapped). Ins of window w alias outs of window w+1.
  - Maximum physical address is 8+16*NWINDOWS-1, which fits in 8 bits.
- Latency: PhysAddr and PhysLd are valid 1 cycle after AddrValid/LogAddr.
  - When AddrValid=0: PhysLd=0 and PhysAddr holds its last value.
- Reset mid-operation clears all state immediately; pending pulses are dropped.

Optional Feature:
- Macro WIN_DEPTH_EN.
- Defined:
  - Adds output Depth (4 bits), the saturating count of successful SAVEs minus successful RESTOREs.
  - Reset to 0. Saturates at 15 and 0. CwpLd clears it to 0.
  - Depth increments only on a SAVE that moves Cwp, and decrements only on a RESTORE that moves Cwp.
- Undefined: no Depth port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset: drive Reset_n=0 mid-cycle -> Cwp=0, Wim=0, PhysAddr=0, PhysLd=0 immediately, without waiting for Clk.
- Mapping at Cwp=0, NWINDOWS=4: LogAddr=5 -> 5; 8 -> 8; 16 -> 16; 24 -> 24; 31 -> 31. PhysLd high exactly 1 cycle after each AddrValid.
- SAVE at Cwp=0, Wim=0 -> Cwp=3. Then LogAddr=24 -> PhysAddr=8, which equals r8 at Cwp=0. Then RESTORE -> Cwp=0.
- Wim=4'b0100, Cwp=3, SAVE -> WinOverflow=1 for one cycle, Cwp stays 3. Wim=4'b0001, Cwp=3, RESTORE -> WinUnderflow=1, Cwp stays 3.
- Save=Restore=1 at Cwp=1 -> BadOp pulse, Cwp=1. CwpLd=1, CwpIn=2, Save=1 -> Cwp=2, no pulses.
- With WIN_DEPTH_EN defined: 3 SAVEs then 1 RESTORE, Wim=0 -> Depth=2. A masked SAVE leaves Depth unchanged.
